// File: rtl/bp_pkg.sv
// Shared definitions for the branch outcome predictor: 2-bit counter
// encodings and the default pattern-table size.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_t;

    localparam int BP_IDX_BITS = 6;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_state_t i_state,
    input  logic       i_taken,
    output ctr_state_t o_next
);

    always_comb begin
        o_next = i_state;
        case (i_state)
            SNT: o_next = i_taken ? WNT : SNT;
            WNT: o_next = i_taken ? WT  : SNT;
            WT:  o_next = i_taken ? ST  : WNT;
            ST:  o_next = i_taken ? ST  : WT;
            default: o_next = i_state;
        endcase
    end

endmodule

// File: rtl/branch_outcome_predictor.sv
// Untagged bimodal branch predictor with misprediction pulse and saturating
// resolved-branch / misprediction statistics.
module branch_outcome_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Pred_PC,
    output logic        Pred_Taken,
    input  logic        Upd_Valid,
    input  logic [31:0] Upd_PC,
    input  logic        Upd_Taken,
    input  logic        Upd_PredTaken,
    output logic        Mispredict,
    input  logic        Stat_Clear,
    output logic [31:0] Branch_Count,
    output logic [31:0] Mispredict_Count
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    ctr_state_t             r_table [ENTRIES];
    logic                   r_mispredict;
    logic [31:0]            r_branch_count;
    logic [31:0]            r_mispredict_count;

    logic [IDX_BITS-1:0]    w_pred_idx;
    logic [IDX_BITS-1:0]    w_upd_idx;
    ctr_state_t             w_upd_cur;
    ctr_state_t             w_upd_next;
    logic                   w_wrong;
    logic                   w_unused_bits;

    // Word-aligned PCs: the low two bits and the bits above the index are dropped.
    assign w_pred_idx    = Pred_PC[IDX_BITS+1:2];
    assign w_upd_idx     = Upd_PC[IDX_BITS+1:2];
    assign w_unused_bits = ^{Pred_PC[31:IDX_BITS+2], Pred_PC[1:0],
                             Upd_PC[31:IDX_BITS+2], Upd_PC[1:0]};

    assign w_upd_cur = r_table[w_upd_idx];
    assign w_wrong   = Upd_Valid && (Upd_Taken != Upd_PredTaken);

    sat_counter2 u_sat_counter2 (
        .i_state (w_upd_cur),
        .i_taken (Upd_Taken),
        .o_next  (w_upd_next)
    );

    // Prediction reads the registered table, so a same-cycle update is not visible.
    assign Pred_Taken = r_table[w_pred_idx][1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= WNT;
            end
        end else if (Upd_Valid) begin
            r_table[w_upd_idx] <= w_upd_next;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_wrong;
        end
    end

    // Stat_Clear wins over a same-edge increment; counters stick at all-ones.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (Stat_Clear) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (Upd_Valid && (r_branch_count != STAT_MAX)) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_wrong && (r_mispredict_count != STAT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign Mispredict       = r_mispredict;
    assign Branch_Count     = r_branch_count;
    assign Mispredict_Count = r_mispredict_count;

endmodule

// File: doc/branch_outcome_predictor.md
BRANCH_OUTCOME_PREDICTOR -- requirements
Module: branch_outcome_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 6, meaning the log2 of the number of pattern-table entries (64).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Pred_PC, input, 32 bits: fetch-stage PC to predict.
REQ-005 SHALL have port Pred_Taken, output, 1 bit: predicted direction for Pred_PC.
REQ-006 SHALL have port Upd_Valid, input, 1 bit: a resolved conditional branch is presented this cycle.
REQ-007 SHALL have port Upd_PC, input, 32 bits: PC of the resolved branch.
REQ-008 SHALL have port Upd_Taken, input, 1 bit: actual outcome, which is the compare-unit result.
REQ-009 SHALL have port Upd_PredTaken, input, 1 bit: prediction carried down the pipe with that branch.
REQ-010 SHALL have port Mispredict, output, 1 bit: registered one-cycle pulse on a wrong prediction.
REQ-011 SHALL have port Stat_Clear, input, 1 bit: synchronous clear of the statistics counters.
REQ-012 SHALL have port Branch_Count, output, 32 bits: number of resolved branches.
REQ-013 SHALL have port Mispredict_Count, output, 32 bits: number of mispredictions.

Function
REQ-014 SHALL hold 2^IDX_BITS two-bit saturating counters, indexed by PC[IDX_BITS+1:2].
REQ-015 SHALL use counter encoding SNT=00, WNT=01, WT=10, ST=11.
REQ-016 SHALL drive Pred_Taken combinationally in the same cycle as Pred_PC: Pred_Taken = counter[idx(Pred_PC)][1].
REQ-017 SHALL, when Upd_Valid=1, on the next edge increment counter[idx(Upd_PC)] if Upd_Taken=1 (saturating at ST), otherwise decrement it (saturating at SNT).
REQ-018 SHALL leave the table unchanged on any edge where Upd_Valid=0.
REQ-019 SHALL, when idx(Pred_PC) equals idx(Upd_PC) in the same cycle, return the pre-update value on Pred_Taken (read-old, no bypass).
REQ-020 SHALL assert Mispredict for exactly the one cycle after an edge where Upd_Valid=1 and Upd_Taken differs from Upd_PredTaken; Mispredict SHALL be 0 otherwise.
REQ-021 SHALL increment Branch_Count on each edge with Upd_Valid=1, and increment Mispredict_Count on each edge where the REQ-020 condition holds.
REQ-022 SHALL saturate both statistics counters at 32'hFFFFFFFF (no wrap-around).
REQ-023 SHALL give Stat_Clear priority over a simultaneous increment: both counters become 0 on that edge and that branch is not counted; table update and Mispredict are unaffected.
REQ-024 SHALL carry no tags: aliasing branches share an entry by design.

Reset
REQ-025 SHALL, while Rst_n=0, set every table entry to WNT (01) and set Mispredict, Branch_Count and Mispredict_Count to 0, independent of Clk.
REQ-026 SHALL apply an Rst_n assertion mid-operation immediately and discard any pending update.
REQ-027 SHALL read Pred_Taken=0 for every PC after reset.

Structure
REQ-028 SHALL place the counter-state encodings (SNT/WNT/WT/ST) and the default IDX_BITS in a shared package, bp_pkg.
REQ-029 SHALL implement the saturating next-state function as the sub-module sat_counter2 (inputs state and taken; output next state).

Verification
REQ-030 Reset check: release reset, sweep Pred_PC over all 64 indices -> Pred_Taken=0 everywhere, and both statistics counters read 0.
REQ-031 Training and saturation: issue 3 updates at PC 0x00400010 with Upd_Taken=1 -> entry reads 01->10->11->11; Pred_Taken=1 after the first update.
REQ-032 Mispredict pulse: Upd_Taken=1 with Upd_PredTaken=0 -> Mispredict=1 for one cycle; Branch_Count=1 and Mispredict_Count=1.
REQ-033 Read-old collision: Pred_PC=Upd_PC=0x00400020 with entry at WNT and Upd_Taken=1 -> Pred_Taken=0 that cycle and 1 the next cycle.
REQ-034 Aliasing and clear: PCs 0x00400004 and 0x00400104 share index 1 and are observed to share training; Stat_Clear together with Upd_Valid -> counters read 0 and the table entry is still updated.
REQ-035 Saturation and mid-operation reset: preload Branch_Count=FFFFFFFF, then update -> it stays FFFFFFFF; assert Rst_n=0 mid-stream -> all outputs 0 asynchronously.
